// File: rtl/cache_pkg.sv
// cache_pkg: shared CacheRequest layout, request types and poison constants for the cache issue path.
package cache_pkg;
  localparam int CACHE_REQUEST_WIDTH = 104;
  localparam int CACHE_SETS = 64;
  localparam int CACHE_BLOCK_SIZE = 16;
  localparam int SET_LSB = 0;
  localparam int SET_MSB = 2;
  localparam int WE_LSB = 3;
  localparam int WE_MSB = 6;
  localparam int VALID_BIT = 7;
  localparam int TYPE_LSB = 8;
  localparam int TYPE_MSB = 39;
  localparam int WDATA_LSB = 40;
  localparam int WDATA_MSB = 71;
  localparam int TAG_LSB = 72;
  localparam int TAG_MSB = 93;
  localparam int OFF_LSB = 94;
  localparam int OFF_MSB = 97;
  localparam int IDX_LSB = 98;
  localparam int IDX_MSB = 103;
  localparam logic [31:0] CACHE_READ = 32'd0;
  localparam logic [31:0] CACHE_WRITE = 32'd1;
  localparam logic [31:0] CACHE_DRAM_FILL = 32'd2;
  localparam logic [31:0] WORD_POISON = 32'h0BADF00D;
  localparam logic [21:0] CACHE_PHYSICAL_TAG_POISON = 22'h277BAD;
  typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} issue_state_e;
  typedef struct packed {
    logic [5:0] index;
    logic [3:0] block_offset;
    logic [21:0] tag;
    logic [31:0] write_data;
    logic [31:0] request_type;
    logic is_valid;
    logic [3:0] write_enable;
    logic [2:0] write_set;
  } cache_req_t;
endpackage

// File: rtl/cache_request_fifo.sv
// cache_request_fifo: DEPTH x W synchronous FIFO with wrapping pointers and an occupancy count.
module cache_request_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 104
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/cache_request_issue.sv
// cache_request_issue: buffers CacheRequest words and issues them to the data/tag arrays.
// Optional CACHE_REQ_POISON_CHECK_EN adds poison_err, flagging reads with non-poison data/tag.
module cache_request_issue
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REQ_W = CACHE_REQUEST_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] req_in,
  input  logic             req_in_valid,
  output logic             req_in_ready,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [2:0]       mem_set,
  output logic [5:0]       mem_index,
  output logic [1:0]       mem_word,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             mem_tag_we,
  output logic [21:0]      mem_tag_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  input  logic             resp_ready
`ifdef CACHE_REQ_POISON_CHECK_EN
  , output logic           poison_err
`endif
);
  issue_state_e state, nxt;
  cache_req_t hd;
  logic [REQ_W-1:0] head;
  logic full, empty, push, issue, rd, wr, fill, unused;
  assign push = req_in_valid && !full && req_in[VALID_BIT];
  assign req_in_ready = !full;
  cache_request_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(issue), .din(req_in),
    .full(full), .empty(empty), .head(head)
  );
  assign hd = head;
  assign unused = ^{hd.is_valid, hd.block_offset[1:0]};
  // Reset gates issue so the arrays never see a strobe while the queue is being flushed.
  assign issue = !rst && state == IDLE && !empty;
  assign rd = hd.request_type == CACHE_READ;
  assign wr = hd.request_type == CACHE_WRITE;
  assign fill = hd.request_type == CACHE_DRAM_FILL;
  assign resp_valid = state == RESP;
  always_comb begin
    mem_en = issue && (rd || wr || fill);
    mem_we = !mem_en ? 4'h0 : fill ? 4'hF : wr ? hd.write_enable : 4'h0;
    mem_set = mem_en ? hd.write_set : '0;
    mem_index = mem_en ? hd.index : '0;
    mem_word = mem_en ? hd.block_offset[3:2] : '0;
    mem_wdata = mem_en ? hd.write_data : '0;
    mem_tag_we = issue && fill;
    mem_tag_wdata = mem_tag_we ? hd.tag : '0;
    nxt = state == IDLE ? ((issue && rd) ? READ_WAIT : IDLE) :
          state == READ_WAIT ? RESP : (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp_data <= '0;
    end else begin
      state <= nxt;
      if (state == READ_WAIT) resp_data <= mem_rdata;
    end
  end
`ifdef CACHE_REQ_POISON_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) poison_err <= 1'b0;
    else poison_err <= issue && rd && (hd.write_data != WORD_POISON || hd.tag != CACHE_PHYSICAL_TAG_POISON);
  end
`endif
endmodule

// File: tb/tb_cache_request_issue.sv
// tb_cache_request_issue: directed vectors, corner sequences and a randomized scoreboard run.
module tb_cache_request_issue;
  import cache_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [103:0] req_in;
  logic req_in_valid, req_in_ready, mem_en, mem_tag_we, resp_valid, resp_ready;
  logic [3:0] mem_we;
  logic [2:0] mem_set;
  logic [5:0] mem_index;
  logic [1:0] mem_word;
  logic [31:0] mem_wdata, mem_rdata, resp_data;
  logic [21:0] mem_tag_wdata;
`ifdef CACHE_REQ_POISON_CHECK_EN
  logic poison_err;
`endif
  always #5 clk = ~clk;

  cache_request_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_set(mem_set), .mem_index(mem_index), .mem_word(mem_word),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_tag_we(mem_tag_we), .mem_tag_wdata(mem_tag_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready)
`ifdef CACHE_REQ_POISON_CHECK_EN
    , .poison_err(poison_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int s, input int i, input int w);
    return 32'(s * 1000003 + i * 7919 + w * 31) ^ 32'h5A5A1234;
  endfunction

  // Behavioural data array: written by whatever the DUT issues, read one cycle later.
  logic [31:0] dmem [8][64][4];
  logic init_req = 1'b0;
  always @(posedge clk) begin
    mem_rdata <= dmem[mem_set][mem_index][mem_word];
    if (init_req) begin
      for (int s = 0; s < 8; s++)
        for (int i = 0; i < 64; i++)
          for (int w = 0; w < 4; w++) dmem[s][i][w] = init_word(s, i, w);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) dmem[mem_set][mem_index][mem_word][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [103:0] mk(input logic [31:0] typ, input logic v, input logic [3:0] we,
                                      input logic [2:0] st, input logic [5:0] ix, input logic [3:0] off,
                                      input logic [31:0] wd, input logic [21:0] tg);
    return {ix, off, tg, wd, typ, v, we, st};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [103:0] req;
    logic en;
    logic [3:0] we;
    logic [1:0] word;
    logic tag_we;
    logic [21:0] tagw;
    string nm;
  } vec_t;

  typedef struct packed {
    logic [3:0] we;
    logic [2:0] st;
    logic [5:0] ix;
    logic [1:0] w;
    logic [31:0] wd;
    logic tw;
    logic [21:0] tg;
  } iss_t;

  vec_t tv[6];
  iss_t iss_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] marr [8][64][4];

  task automatic rnd_sample;
    iss_t got, exp;
    if (mem_en) begin
      got = '{mem_we, mem_set, mem_index, mem_word, (mem_we != 0) ? mem_wdata : 32'h0,
              mem_tag_we, mem_tag_we ? mem_tag_wdata : 22'h0};
      if (iss_q.size() == 0) chk("rnd_unexpected_issue", 1, 0);
      else begin
        exp = iss_q.pop_front();
        chk("rnd_issue", got, exp);
      end
    end
    if (resp_valid && resp_ready) begin
      if (resp_q.size() == 0) chk("rnd_unexpected_resp", 1, 0);
      else chk("rnd_resp", resp_data, resp_q.pop_front());
    end
  endtask

  task automatic model_enqueue(input logic [31:0] typ, input logic v, input logic [3:0] we, input logic [2:0] st,
                               input logic [5:0] ix, input logic [3:0] off, input logic [31:0] wd, input logic [21:0] tg);
    logic [1:0] w;
    w = off[3:2];
    if (!v || typ > 2) return;
    if (typ == CACHE_READ) begin
      resp_q.push_back(marr[st][ix][w]);
      iss_q.push_back('{4'h0, st, ix, w, 32'h0, 1'b0, 22'h0});
    end else if (typ == CACHE_WRITE) begin
      for (int b = 0; b < 4; b++) if (we[b]) marr[st][ix][w][b*8 +: 8] = wd[b*8 +: 8];
      iss_q.push_back('{we, st, ix, w, (we != 0) ? wd : 32'h0, 1'b0, 22'h0});
    end else begin
      marr[st][ix][w] = wd;
      iss_q.push_back('{4'hF, st, ix, w, wd, 1'b1, tg});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] typ, wd;
    logic v;
    logic [3:0] we, off;
    logic [2:0] st;
    logic [5:0] ix;
    logic [21:0] tg;
    int en_cnt, n, t;
    tv[0] = '{mk(CACHE_WRITE, 1'b1, 4'b0011, 3'd5, 6'd1, 4'h4, 32'h11223344, 22'h0), 1'b1, 4'b0011, 2'd1, 1'b0, 22'h0, "tv_write"};
    tv[1] = '{mk(CACHE_DRAM_FILL, 1'b1, 4'b0000, 3'd2, 6'd9, 4'h0, 32'hA5A5A5A5, 22'h12345), 1'b1, 4'hF, 2'd0, 1'b1, 22'h12345, "tv_fill"};
    tv[2] = '{mk(CACHE_WRITE, 1'b0, 4'hF, 3'd1, 6'd2, 4'h0, 32'hDEAD0000, 22'h0), 1'b0, 4'h0, 2'd0, 1'b0, 22'h0, "tv_invalid"};
    tv[3] = '{mk(32'd7, 1'b1, 4'hF, 3'd1, 6'd3, 4'h0, 32'hDEAD0001, 22'h0), 1'b0, 4'h0, 2'd0, 1'b0, 22'h0, "tv_badtype"};
    tv[4] = '{mk(CACHE_WRITE, 1'b1, 4'b1000, 3'd0, 6'd4, 4'hF, 32'h0, 22'h0), 1'b1, 4'b1000, 2'd3, 1'b0, 22'h0, "tv_unaligned"};
    tv[5] = '{mk(CACHE_READ, 1'b1, 4'hF, 3'd3, 6'd5, 4'h3, 32'h0, 22'h0), 1'b1, 4'h0, 2'd0, 1'b0, 22'h0, "tv_read"};
    rst = 1'b1;
    req_in = '0;
    req_in_valid = 1'b0;
    resp_ready = 1'b0;
    init_req = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    init_req = 1'b0;
    tick;
    chk("reset_outputs", {mem_en, mem_we, mem_set, mem_index, mem_word, mem_wdata, mem_tag_we, mem_tag_wdata, resp_valid, resp_data}, 0);
    chk("reset_ready", req_in_ready, 1);

    // Single read: seed the word with a write, then time the read against its enqueue cycle.
    req_in = mk(CACHE_WRITE, 1'b1, 4'hF, 3'd1, 6'h2A, 4'h8, 32'hCAFE0001, 22'h0);
    req_in_valid = 1'b1;
    tick;
    req_in_valid = 1'b0;
    tick;
    req_in = mk(CACHE_READ, 1'b1, 4'h0, 3'd1, 6'h2A, 4'h8, 32'h0, 22'h0);
    req_in_valid = 1'b1;
    chk("rd_ready", req_in_ready, 1);
    tick;
    req_in_valid = 1'b0;
    chk("rd_issue", {mem_en, mem_we, mem_set, mem_index, mem_word}, {1'b1, 4'h0, 3'd1, 6'h2A, 2'd2});
`ifdef CACHE_REQ_POISON_CHECK_EN
    chk("poison_n1", poison_err, 0);
`endif
    tick;
    chk("rd_wait_novalid", resp_valid, 0);
`ifdef CACHE_REQ_POISON_CHECK_EN
    chk("poison_n2", poison_err, 1);
`endif
    tick;
    chk("rd_resp", {resp_valid, resp_data}, {1'b1, 32'hCAFE0001});
`ifdef CACHE_REQ_POISON_CHECK_EN
    chk("poison_n3", poison_err, 0);
`endif
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("rd_resp_done", resp_valid, 0);

`ifdef CACHE_REQ_POISON_CHECK_EN
    req_in = mk(CACHE_READ, 1'b1, 4'h0, 3'd0, 6'd7, 4'h0, WORD_POISON, CACHE_PHYSICAL_TAG_POISON);
    req_in_valid = 1'b1;
    tick;
    req_in_valid = 1'b0;
    tick;
    chk("poison_clean", poison_err, 0);
    resp_ready = 1'b1;
    repeat (3) tick;
    resp_ready = 1'b0;
`endif

    for (int i = 0; i < 6; i++) begin
      req_in = tv[i].req;
      req_in_valid = 1'b1;
      tick;
      req_in_valid = 1'b0;
      chk({tv[i].nm, "_en"}, mem_en, tv[i].en);
      chk({tv[i].nm, "_we"}, mem_we, tv[i].we);
      chk({tv[i].nm, "_word"}, mem_word, tv[i].word);
      chk({tv[i].nm, "_tagwe"}, mem_tag_we, tv[i].tag_we);
      if (tv[i].tag_we) chk({tv[i].nm, "_tagw"}, mem_tag_wdata, tv[i].tagw);
      tick;
      chk({tv[i].nm, "_quiet"}, mem_en, 0);
      resp_ready = 1'b1;
      repeat (3) tick;
      resp_ready = 1'b0;
    end

    for (int c = 0; c < 4; c++) begin
      req_in = mk(CACHE_WRITE, 1'b1, 4'b0011, 3'd5, 6'(c), 4'(c * 4), $urandom, 22'h0);
      req_in_valid = c < 3;
      if (c > 0) chk("b2b_issue", {mem_en, mem_we, mem_set, mem_index, resp_valid}, {1'b1, 4'b0011, 3'd5, 6'(c - 1), 1'b0});
      tick;
    end
    req_in_valid = 1'b0;
    chk("b2b_done", {mem_en, resp_valid}, 0);

    req_in = mk(CACHE_READ, 1'b1, 4'h0, 3'd2, 6'd3, 4'h0, 32'h0, 22'h0);
    req_in_valid = 1'b1;
    tick;
    req_in_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin
      tick;
      n++;
    end
    chk("bp_resp_wait", resp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      req_in = mk(CACHE_WRITE, 1'b1, 4'hF, 3'd6, 6'(k), 4'h0, 32'(k), 22'h0);
      req_in_valid = 1'b1;
      chk("bp_ready_fill", req_in_ready, k < 4);
      tick;
    end
    resp_ready = 1'b1;
    chk("bp_full_resp", {req_in_ready, resp_valid}, {1'b0, 1'b1});
    tick;
    resp_ready = 1'b0;
    chk("bp_full_pop", req_in_ready, 0);
    en_cnt = int'(mem_en);
    tick;
    chk("bp_ready_back", req_in_ready, 1);
    en_cnt += int'(mem_en);
    tick;
    req_in_valid = 1'b0;
    repeat (6) begin
      en_cnt += int'(mem_en);
      tick;
    end
    chk("bp_issue_count", en_cnt, 5);

    req_in = mk(CACHE_READ, 1'b1, 4'h0, 3'd0, 6'd4, 4'h0, 32'h0, 22'h0);
    req_in_valid = 1'b1;
    tick;
    req_in = mk(CACHE_WRITE, 1'b1, 4'hF, 3'd0, 6'd5, 4'h0, 32'h1, 22'h0);
    tick;
    req_in_valid = 1'b0;
    chk("rst_readwait", {mem_en, resp_valid}, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_after", {resp_valid, mem_en, req_in_ready}, {1'b0, 1'b0, 1'b1});
    tick;
    chk("rst_fifo_empty", {mem_en, resp_valid}, 0);

    init_req = 1'b1;
    tick;
    init_req = 1'b0;
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 64; i++)
        for (int w = 0; w < 4; w++) marr[s][i][w] = init_word(s, i, w);
    for (int c = 0; c < 800; c++) begin
      t = $urandom_range(0, 9);
      typ = t < 4 ? CACHE_READ : t < 7 ? CACHE_WRITE : t < 9 ? CACHE_DRAM_FILL : 32'($urandom_range(3, 9));
      v = $urandom_range(0, 7) != 0;
      we = 4'($urandom);
      st = 3'($urandom);
      ix = 6'($urandom_range(0, 3));
      off = 4'($urandom);
      wd = $urandom;
      tg = 22'($urandom);
      req_in = mk(typ, v, we, st, ix, off, wd, tg);
      req_in_valid = $urandom_range(0, 1) == 1;
      resp_ready = $urandom_range(0, 3) != 0;
      rnd_sample();
      if (req_in_valid && req_in_ready) model_enqueue(typ, v, we, st, ix, off, wd, tg);
      tick;
    end
    req_in_valid = 1'b0;
    resp_ready = 1'b1;
    n = 0;
    while ((iss_q.size() != 0 || resp_q.size() != 0) && n < 100) begin
      rnd_sample();
      tick;
      n++;
    end
    chk("rnd_drain_issue", iss_q.size(), 0);
    chk("rnd_drain_resp", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_request_issue.md
Name: cache_request_issue

Overview:
- Sits directly downstream of the cache request builder; consumes the 104-bit flat CacheRequest word.
- Buffers requests in a small FIFO, unpacks the fields, and issues them to the set-associative data/tag arrays.
- Returns read data to the requester over a valid/ready response channel.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2).
- REQ_W, 104, flat request width; fixed to CACHE_REQUEST_WIDTH.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_in  in  104  flat request: [2:0] writeSet, [6:3] writeEnable, [7] isValid, [39:8] requestType, [71:40] writeData, [93:72] tag, [97:94] blockOffset, [103:98] index
- req_in_valid  in  1  upstream offers req_in
- req_in_ready  out  1  equals !full
- mem_en  out  1  array access strobe
- mem_we  out  4  byte write enables; zero on reads
- mem_set  out  3  way select, taken from writeSet
- mem_index  out  6  set index
- mem_word  out  2  word in the 16-byte block, taken from blockOffset[3:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  array read data, valid 1 cycle after mem_en
- mem_tag_we  out  1  tag write strobe, DRAM_FILL only
- mem_tag_wdata  out  22  physical tag
- resp_valid  out  1  read response pending
- resp_data  out  32  read word
- resp_ready  in  1  consumer accepts the response

Behaviour:
- Reset: FIFO empty, state IDLE. req_in_ready=1 on the cycle after reset. All mem_* outputs, resp_valid and resp_data are 0.
- Enqueue occurs when req_in_valid && req_in_ready. A beat with isValid=0 is accepted but not stored. There is no enqueue while full, even if a pop happens in the same cycle.
- FIFO uses wrapping read/write pointers and a count of width clog2(DEPTH+1). Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, READ_WAIT, RESP.
- IDLE with FIFO non-empty: mem_* are driven combinationally from the head entry, mem_en=1, and the head is popped.
  - READ (type 0): mem_we=0. Next state READ_WAIT.
  - WRITE (type 1): mem_we=writeEnable. Stay in IDLE, so back-to-back issue is possible.
  - DRAM_FILL (type 2): mem_we=4'hF, mem_tag_we=1, mem_tag_wdata=tag. Stay in IDLE.
  - Any other type: popped with mem_en=0 and dropped.
- READ_WAIT: resp_data <= mem_rdata. Next state RESP.
- RESP: resp_valid=1, resp_data held stable. On resp_ready, go to IDLE. Nothing is issued in the RESP cycle.
- Latency: a request enqueued at cycle N issues at N+1 (FIFO empty, IDLE). Read data sits on mem_rdata at N+2. resp_valid rises at N+3.
- The FIFO keeps accepting requests while the FSM is in READ_WAIT or RESP.
- blockOffset[1:0] is ignored, so accesses are word-aligned.
- Synchronous reset mid-operation discards all queued and in-flight requests. resp_valid=0 on the next cycle.

Optional Feature:
- CACHE_REQ_POISON_CHECK_EN. When defined, adds output poison_err (1 bit, registered).
- poison_err pulses for one cycle after a READ issues whose writeData != 32'hBADF00D or whose tag != 22'h277BAD.
- The request is still serviced normally.
- When the macro is undefined, the port and its logic are absent.

Decomposition:
- Shared package cache_pkg holds:
  - CACHE_REQUEST_WIDTH, CACHE_SETS, CACHE_BLOCK_SIZE;
  - field bit-range constants;
  - CACHE_READ, CACHE_WRITE, CACHE_DRAM_FILL;
  - WORD_POISON, CACHE_PHYSICAL_TAG_POISON.
- Sub-module: cache_request_fifo, a generic DEPTH x REQ_W synchronous FIFO with push, pop, full, empty and head outputs.

Test Plan:
- Single read: index=6'h2A, offset=4'h8, array returns 32'hCAFE0001 -> mem_en at N+1 with mem_index=6'h2A, mem_word=2'd2, mem_we=0; resp_valid at N+3 with resp_data=32'hCAFE0001.
- Back-to-back writes: 3 writes, writeEnable=4'b0011, writeSet=3'd5 -> three consecutive mem_en cycles, each mem_we=4'b0011 and mem_set=3'd5; resp_valid stays 0.
- Backpressure: 5 requests issued while a read is held in RESP with resp_ready=0 -> req_in_ready=0 after the 4th is accepted; it returns to 1 one cycle after resp_ready=1 and the next pop.
- DRAM_FILL: tag=22'h12345 -> mem_tag_we=1, mem_tag_wdata=22'h12345, mem_we=4'hF for one cycle.
- Invalid and bad type: isValid=0 beat -> no mem_en; requestType=7 -> popped with no mem_en. Reset asserted during READ_WAIT -> resp_valid=0 and FIFO empty on the next cycle.
- With CACHE_REQ_POISON_CHECK_EN: read with writeData=0 -> poison_err=1 for exactly one cycle, and the response is still delivered.
